alu_uart_ctrl: RTL

ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

---
 rtl/alu_uart_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_uart_ctrl.sv
// ---------------------------------------------------------------------------
// alu_uart_ctrl: collects operand A, operand B and an opcode byte from a UART
// receiver, presents them to an external combinational ALU, then sends the
// ALU result back through the UART transmitter.
//
// Optional feature: define ALU_UART_CTRL_TIMEOUT_EN to enable an inter-byte
// timeout in WAIT_B/WAIT_OP, which adds the timeout_tick output.
//
// Ports:
//   clk           in   single clock, rising edge
//   reset         in   asynchronous active-low reset
//   rx_done_tick  in   one-cycle pulse, rx_data valid
//   rx_data       in   received byte [NB_DATA]
//   tx_done_tick  in   one-cycle pulse, transmitter finished
//   alu_result    in   combinational ALU output [NB_DATA]
//   alu_a, alu_b  out  registered operands [NB_DATA]
//   alu_op        out  registered opcode [NB_OP]
//   tx_start      out  registered one-cycle transmit request
//   tx_data       out  registered byte to transmit [NB_DATA]
//   timeout_tick  out  one-cycle timeout pulse (only with the macro)
//   busy          out  high in SEND or WAIT_TX
//   overrun       out  one-cycle pulse, a received byte was dropped
// ---------------------------------------------------------------------------
module alu_uart_ctrl #(
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned NB_OP       = 6,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_done_tick,
  input  logic [NB_DATA-1:0] rx_data,
  input  logic               tx_done_tick,
  input  logic [NB_DATA-1:0] alu_result,
  output logic [NB_DATA-1:0] alu_a,
  output logic [NB_DATA-1:0] alu_b,
  output logic [NB_OP-1:0]   alu_op,
  output logic               tx_start,
  output logic [NB_DATA-1:0] tx_data,
`ifdef ALU_UART_CTRL_TIMEOUT_EN
  output logic               timeout_tick,
`endif
  output logic               busy,
  output logic               overrun
);

  localparam logic [2:0] StWaitA  = 3'd0;
  localparam logic [2:0] StWaitB  = 3'd1;
  localparam logic [2:0] StWaitOp = 3'd2;
  localparam logic [2:0] StSend   = 3'd3;
  localparam logic [2:0] StWaitTx = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d;
  logic [NB_DATA-1:0] alu_b_q, alu_b_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               overrun_q, overrun_d;

`ifdef ALU_UART_CTRL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`endif

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overrun_d  = 1'b0;
`ifdef ALU_UART_CTRL_TIMEOUT_EN
    cnt_d      = '0;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      StWaitA: begin
        if (rx_done_tick) begin
          alu_a_d = rx_data;
          state_d = StWaitB;
        end
      end
      StWaitB: begin
        if (rx_done_tick) begin
          alu_b_d = rx_data;
          state_d = StWaitOp;
        end
`ifdef ALU_UART_CTRL_TIMEOUT_EN
        // A byte arriving in the last cycle takes priority over the timeout.
        else if (cnt_q == CntLast) begin
          state_d   = StWaitA;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StWaitOp: begin
        if (rx_done_tick) begin
          alu_op_d = rx_data[NB_OP-1:0];
          state_d  = StSend;
        end
`ifdef ALU_UART_CTRL_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          state_d   = StWaitA;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StSend: begin
        // Operands have been stable for a full cycle, so alu_result is settled.
        tx_data_d  = alu_result;
        tx_start_d = 1'b1;
        state_d    = StWaitTx;
        overrun_d  = rx_done_tick;
      end
      StWaitTx: begin
        if (tx_done_tick) begin
          state_d = StWaitA;
        end
        overrun_d = rx_done_tick;
      end
      default: state_d = StWaitA;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StWaitA;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef ALU_UART_CTRL_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
`ifdef ALU_UART_CTRL_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q == StSend) || (state_q == StWaitTx);
`ifdef ALU_UART_CTRL_TIMEOUT_EN
  assign timeout_tick = timeout_q;
`endif

endmodule
